pkt_hdr_parser: RTL and testbench

PKT_HDR_PARSER -- requirements
Module: pkt_hdr_parser

---
 rtl/pkt_hdr_parser.sv | 172 +++++++++++++++++
 tb/tb_pkt_hdr_parser.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_hdr_parser.sv
// Streaming Ethernet / VLAN / LLC / IPv4 / L4 header parser. Fields are picked off the
// byte stream by offset compare; ready pulses once per frame when the header is done.
module pkt_hdr_parser #(
  parameter int MAX_VLAN = 2,
  parameter int CNT_W    = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  d,
  input  logic        strobe,
  input  logic        din_valid,
  input  logic        din_last,
  output logic        ready,
  output logic        trunc,
  output logic [1:0]  frame,
  output logic [47:0] dstmac,
  output logic [47:0] srcmac,
  output logic [1:0]  vlan_cnt,
  output logic [11:0] vlan_id,
  output logic [15:0] ethproto,
  output logic [7:0]  ipproto,
  output logic [31:0] srcip4,
  output logic [31:0] dstip4,
  output logic [1:0]  fragment_flag,
  output logic [12:0] fragment_shift,
  output logic        is_fragment,
  output logic [15:0] srcport,
  output logic [15:0] dstport,
  output logic [15:0] icmp
);
  typedef enum logic [2:0] {IDLE, MAC, TYPE, VLAN, LLC, IPV4, L4, DONE} state_t;
  localparam logic [1:0] VLAN_MAX = 2'(MAX_VLAN);

  state_t           state, next_state, cur;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       ihl;
  logic [7:0]       prev;
  logic [15:0]      t_val;
  logic             active, is_tag, l4_icmp, l4_go;
  logic             done_ok, done_trunc, set_eth;
  int               off_i, ip_base_i, ip_i, l4_i;

  // A strobe byte is byte 0 of a new frame no matter what state we are in.
  assign cur       = strobe ? MAC : state;
  assign off_i     = strobe ? 0 : int'(cnt);
  assign active    = (strobe | din_valid) && (cur != IDLE) && (cur != DONE);
  assign ip_base_i = 14 + 4 * int'(vlan_cnt);
  assign ip_i      = off_i - ip_base_i;
  assign l4_i      = ip_i - 4 * int'(ihl);

  assign t_val       = {prev, d};
  assign is_tag      = (t_val == 16'h8100 || t_val == 16'h88A8) && (vlan_cnt < VLAN_MAX);
  assign l4_icmp     = (ipproto == 8'h01);
  assign l4_go       = (fragment_shift == '0) && (ipproto == 8'h06 || ipproto == 8'h11 || l4_icmp);
  assign is_fragment = fragment_flag[0] | (fragment_shift != '0);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    done_ok    = 1'b0;
    done_trunc = 1'b0;
    set_eth    = 1'b0;
    if (active) begin
      next_state = cur;
      unique case (cur)
        MAC:  if (off_i == 11) next_state = TYPE;
        TYPE: if (off_i == ip_base_i - 1) begin
                if (is_tag) next_state = VLAN;
                else if (t_val > 16'h05DC) begin
                  set_eth = 1'b1;
                  if (t_val == 16'h0800) next_state = IPV4;
                  else done_ok = 1'b1;
                end else next_state = LLC;
              end
        VLAN: if (off_i == ip_base_i + 1) next_state = TYPE;
        LLC:  done_ok = (off_i == ip_base_i + 1);
        IPV4: if (ip_i == 0) done_trunc = (d[3:0] < 4'd5);
              else if (ip_i == 4 * int'(ihl) - 1) begin
                if (l4_go) next_state = L4;
                else done_ok = 1'b1;
              end
        L4:   done_ok = (l4_i == (l4_icmp ? 1 : 3));
        default: ;
      endcase
      if (din_last && !done_ok) done_trunc = 1'b1;
      if (done_ok || done_trunc) next_state = DONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      prev           <= '0;
      ihl            <= '0;
      ready          <= 1'b0;
      trunc          <= 1'b0;
      frame          <= '0;
      dstmac         <= '0;
      srcmac         <= '0;
      vlan_cnt       <= '0;
      vlan_id        <= '0;
      ethproto       <= '0;
      ipproto        <= '0;
      srcip4         <= '0;
      dstip4         <= '0;
      fragment_flag  <= '0;
      fragment_shift <= '0;
      srcport        <= '0;
      dstport        <= '0;
      icmp           <= '0;
    end else begin
      state <= next_state;
      ready <= 1'b0;
      // NOTE: the clear below and the byte-0 capture further down land on the same
      // edge; with non-blocking assignments the later capture wins for its bits.
      if (strobe) begin
        trunc          <= 1'b0;
        frame          <= '0;
        dstmac         <= '0;
        srcmac         <= '0;
        vlan_cnt       <= '0;
        vlan_id        <= '0;
        ethproto       <= '0;
        ipproto        <= '0;
        srcip4         <= '0;
        dstip4         <= '0;
        fragment_flag  <= '0;
        fragment_shift <= '0;
        srcport        <= '0;
        dstport        <= '0;
        icmp           <= '0;
        ihl            <= '0;
      end
      if (active) begin
        cnt  <= CNT_W'(off_i + 1);
        prev <= d;
        unique case (cur)
          MAC:  if (off_i < 6) dstmac[8*(5-off_i) +: 8] <= d;
                else srcmac[8*(11-off_i) +: 8] <= d;
          TYPE: if (set_eth) ethproto <= t_val;
          VLAN: if (off_i == ip_base_i + 1) begin
                  vlan_cnt <= vlan_cnt + 2'd1;
                  if (vlan_cnt == 2'd0) vlan_id <= {prev[3:0], d};
                end
          LLC:  if (off_i == ip_base_i + 1)
                  frame <= (t_val == 16'hFFFF) ? 2'b01 : (t_val == 16'hAAAA) ? 2'b10 : 2'b11;
          IPV4: begin
                  if (ip_i == 0) ihl <= d[3:0];
                  if (ip_i == 6) begin
                    fragment_flag        <= d[6:5];
                    fragment_shift[12:8] <= d[4:0];
                  end
                  if (ip_i == 7) fragment_shift[7:0] <= d;
                  if (ip_i == 9) ipproto <= d;
                  if (ip_i >= 12 && ip_i <= 15) srcip4[8*(15-ip_i) +: 8] <= d;
                  if (ip_i >= 16 && ip_i <= 19) dstip4[8*(19-ip_i) +: 8] <= d;
                end
          L4:   if (l4_icmp) begin
                  if (l4_i <= 1) icmp[8*(1-l4_i) +: 8] <= d;
                end else if (l4_i <= 1) srcport[8*(1-l4_i) +: 8] <= d;
                else dstport[8*(3-l4_i) +: 8] <= d;
          default: ;
        endcase
        if (done_ok || done_trunc) begin
          ready <= 1'b1;
          trunc <= done_trunc;
        end
      end
    end
  end
endmodule

// File: tb/tb_pkt_hdr_parser.sv
// Directed-frame bench for pkt_hdr_parser: the driver queues the expected header of each
// frame as it sends it, and a negedge monitor pops and compares on every ready pulse.
`timescale 1ns/1ps
module tb_pkt_hdr_parser;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  d;
  logic        strobe, din_valid, din_last;
  logic        ready, trunc, is_fragment;
  logic [1:0]  frame, vlan_cnt, fragment_flag;
  logic [47:0] dstmac, srcmac;
  logic [11:0] vlan_id;
  logic [15:0] ethproto, srcport, dstport, icmp;
  logic [7:0]  ipproto;
  logic [31:0] srcip4, dstip4;
  logic [12:0] fragment_shift;

  pkt_hdr_parser #(.MAX_VLAN(2), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .d(d), .strobe(strobe), .din_valid(din_valid),
    .din_last(din_last), .ready(ready), .trunc(trunc), .frame(frame),
    .dstmac(dstmac), .srcmac(srcmac), .vlan_cnt(vlan_cnt), .vlan_id(vlan_id),
    .ethproto(ethproto), .ipproto(ipproto), .srcip4(srcip4), .dstip4(dstip4),
    .fragment_flag(fragment_flag), .fragment_shift(fragment_shift),
    .is_fragment(is_fragment), .srcport(srcport), .dstport(dstport), .icmp(icmp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id; int cyc; logic trunc; logic [1:0] frame; logic [47:0] dst, src;
    logic [1:0] vc; logic [11:0] vid; logic [15:0] eth; logic [7:0] ipp;
    logic [31:0] sip, dip; logic [1:0] ff; logic [12:0] fs; logic isf;
    logic [15:0] sp, dp, ic;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] fb[$];
  int         total = 0, bad = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input int id, input string what, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL v%0d %s got=%h want=%h", id, what, act, want);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (ready === 1'b1) begin
      if (sb.size() == 0) check(-1, "unexpected_ready", 64'(ready), 64'd0);
      else begin
        e = sb.pop_front();
        check(e.id, "ready_cycle", 64'(cyc), 64'(e.cyc));
        check(e.id, "trunc", 64'(trunc), 64'(e.trunc));
        check(e.id, "frame", 64'(frame), 64'(e.frame));
        check(e.id, "dstmac", 64'(dstmac), 64'(e.dst));
        check(e.id, "srcmac", 64'(srcmac), 64'(e.src));
        check(e.id, "vlan_cnt", 64'(vlan_cnt), 64'(e.vc));
        check(e.id, "vlan_id", 64'(vlan_id), 64'(e.vid));
        check(e.id, "ethproto", 64'(ethproto), 64'(e.eth));
        check(e.id, "ipproto", 64'(ipproto), 64'(e.ipp));
        check(e.id, "srcip4", 64'(srcip4), 64'(e.sip));
        check(e.id, "dstip4", 64'(dstip4), 64'(e.dip));
        check(e.id, "fragment_flag", 64'(fragment_flag), 64'(e.ff));
        check(e.id, "fragment_shift", 64'(fragment_shift), 64'(e.fs));
        check(e.id, "is_fragment", 64'(is_fragment), 64'(e.isf));
        check(e.id, "srcport", 64'(srcport), 64'(e.sp));
        check(e.id, "dstport", 64'(dstport), 64'(e.dp));
        check(e.id, "icmp", 64'(icmp), 64'(e.ic));
      end
    end
  end

  function automatic exp_t mk(input int id);
    exp_t e;
    e = '{default: 0};
    e.id  = id;
    e.dst = 48'h001122334455;
    e.src = 48'h66778899AABB;
    return e;
  endfunction

  task automatic put(input logic [7:0] b);
    fb.push_back(b);
  endtask

  task automatic put_n(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) fb.push_back(v[8*i +: 8]);
  endtask

  task automatic start_eth(input logic [15:0] t);
    fb.delete();
    put_n(48'h001122334455, 6);
    put_n(48'h66778899AABB, 6);
    put_n(64'(t), 2);
  endtask

  task automatic put_ip(input logic [3:0] ihl, input logic [7:0] fl, input logic [7:0] ofl,
                        input logic [7:0] pr, input logic [31:0] sip, input logic [31:0] dip);
    put({4'h4, ihl}); put(8'h00); put_n(64'h003C, 2); put_n(64'h0001, 2);
    put(fl); put(ofl); put(8'h40); put(pr); put_n(64'h0, 2);
    put_n(64'(sip), 4); put_n(64'(dip), 4);
    for (int i = 5; i < int'(ihl); i++) put_n(64'h01010101, 4);
  endtask

  task automatic trim(input int n);
    while (fb.size() > n) void'(fb.pop_back());
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      strobe = 1'b0; din_valid = 1'b0; din_last = 1'b0; d = 8'($urandom);
    end
  endtask

  // end_idx: last required byte (expectation queued when it is driven), -1 for none.
  task automatic send(input exp_t e, input int end_idx, input int last_idx,
                      input int gap, input bit strb);
    for (int i = 0; i < fb.size(); i++) begin
      if (gap > 0 && i > 0 && i % gap == 0) idle(1);
      @(posedge clk); #1;
      d = fb[i]; strobe = strb && (i == 0); din_valid = 1'b1; din_last = (i == last_idx);
      if (i == end_idx) begin
        e.cyc = cyc + 1;
        sb.push_back(e);
      end
    end
  endtask

  task automatic check_zero(input int id);
    check(id, "zero_ready", 64'(ready), 64'd0);
    check(id, "zero_trunc", 64'(trunc), 64'd0);
    check(id, "zero_frame_vlan", 64'({frame, vlan_cnt, vlan_id}), 64'd0);
    check(id, "zero_dstmac", 64'(dstmac), 64'd0);
    check(id, "zero_srcmac", 64'(srcmac), 64'd0);
    check(id, "zero_eth_ipp", 64'({ethproto, ipproto}), 64'd0);
    check(id, "zero_ips", {srcip4, dstip4}, 64'd0);
    check(id, "zero_frag", 64'({fragment_flag, fragment_shift, is_fragment}), 64'd0);
    check(id, "zero_l4", 64'({srcport, dstport, icmp}), 64'd0);
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; strobe = 1'b0; din_valid = 1'b0; din_last = 1'b0; d = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero(0);
    reset = 1'b0;
    idle(2);

    // v1: untagged IPv4/TCP, IHL=5, DF set, ports 1234->0050, payload after header
    start_eth(16'h0800);
    put_ip(4'd5, 8'h40, 8'h00, 8'h06, 32'hC0A80102, 32'h0A000001);
    put_n(64'h12340050, 4); put_n(64'hDEADBEEF, 4);
    e = mk(1); e.eth = 16'h0800; e.ipp = 8'h06; e.sip = 32'hC0A80102; e.dip = 32'h0A000001;
    e.ff = 2'b10; e.sp = 16'h1234; e.dp = 16'h0050;
    send(e, 37, fb.size() - 1, 0, 1'b1);
    idle(3);
    check(1, "hold_srcport", 64'(srcport), 64'h1234);

    // v2: QinQ 88A8 (PCP=7, VID 00A) + 8100 (VID 014), IPv4/UDP IHL=6
    start_eth(16'h88A8);
    put_n(64'hE00A8100, 4); put_n(64'h00140800, 4);
    put_ip(4'd6, 8'h00, 8'h00, 8'h11, 32'h0A010203, 32'h0A040506);
    put_n(64'h00351F90, 4); put_n(64'hCAFE, 2);
    e = mk(2); e.vc = 2'd2; e.vid = 12'h00A; e.eth = 16'h0800; e.ipp = 8'h11;
    e.sip = 32'h0A010203; e.dip = 32'h0A040506; e.sp = 16'h0035; e.dp = 16'h1F90;
    send(e, 49, fb.size() - 1, 0, 1'b1);
    idle(2);

    // v3: ICMP first fragment, MF=1 offset 0 -> icmp captured
    start_eth(16'h0800);
    put_ip(4'd5, 8'h20, 8'h00, 8'h01, 32'h0A000002, 32'h0A000003);
    put_n(64'h0800, 2); put_n(64'h1111, 2);
    e = mk(3); e.eth = 16'h0800; e.ipp = 8'h01; e.sip = 32'h0A000002; e.dip = 32'h0A000003;
    e.ff = 2'b01; e.isf = 1'b1; e.ic = 16'h0800;
    send(e, 35, fb.size() - 1, 0, 1'b1);
    idle(2);

    // v4: ICMP later fragment, offset 0x0B9 MF=0 -> ready after IP byte 19, icmp 0
    start_eth(16'h0800);
    put_ip(4'd5, 8'h00, 8'hB9, 8'h01, 32'h0A000002, 32'h0A000003);
    put_n(64'h0800ABCD, 4);
    e = mk(4); e.eth = 16'h0800; e.ipp = 8'h01; e.sip = 32'h0A000002; e.dip = 32'h0A000003;
    e.fs = 13'h0B9; e.isf = 1'b1;
    send(e, 33, fb.size() - 1, 0, 1'b1);
    idle(2);

    // v5/v6: 802.3 length 0x0040 with SNAP (AAAA) and Novell (FFFF)
    start_eth(16'h0040); put_n(64'hAAAA, 2); put_n(64'h03000000, 4);
    e = mk(5); e.frame = 2'b10;
    send(e, 15, fb.size() - 1, 0, 1'b1);
    idle(2);
    start_eth(16'h0040); put_n(64'hFFFF, 2); put_n(64'h03000000, 4);
    e = mk(6); e.frame = 2'b01;
    send(e, 15, fb.size() - 1, 0, 1'b1);
    idle(2);

    // v7: 802.3/LLC 4242 with din_last exactly on the last required byte -> no trunc
    start_eth(16'h0040); put_n(64'h4242, 2);
    e = mk(7); e.frame = 2'b11;
    send(e, 15, 15, 0, 1'b1);
    idle(2);

    // v8: TCP frame ending at byte 30 with valid gaps -> trunc, dstip4 first byte is 00
    start_eth(16'h0800);
    put_ip(4'd5, 8'h40, 8'h00, 8'h06, 32'hC0A80102, 32'h000A0B0C);
    put_n(64'h12340050, 4);
    trim(31);
    e = mk(8); e.trunc = 1'b1; e.eth = 16'h0800; e.ipp = 8'h06; e.sip = 32'hC0A80102; e.ff = 2'b10;
    send(e, 30, 30, 3, 1'b1);
    idle(2);

    // v9: frame cut by a strobe at byte 20; only the new (Novell) frame reports
    start_eth(16'h0800);
    put_ip(4'd5, 8'h40, 8'h00, 8'h06, 32'hC0A80102, 32'h0A000001);
    trim(20);
    send(e, -1, -1, 0, 1'b1);
    start_eth(16'h0040); put_n(64'hFFFF, 2); put_n(64'h03000000, 4);
    e = mk(9); e.frame = 2'b01;
    send(e, 15, fb.size() - 1, 0, 1'b1);
    idle(2);

    // v10: async reset in the middle of a frame, then the frame's tail without strobe
    start_eth(16'h0800);
    put_ip(4'd5, 8'h40, 8'h00, 8'h06, 32'hC0A80102, 32'h0A000001);
    put_n(64'h12340050, 4);
    trim(25);
    send(e, -1, -1, 0, 1'b1);
    #3 reset = 1'b1;
    #1 check_zero(10);
    @(posedge clk); #2 reset = 1'b0;
    fb.delete(); put_n(64'h0A000001, 4); put_n(64'h12340050, 4);
    send(e, -1, fb.size() - 1, 0, 1'b0);
    idle(4);
    check_zero(10);

    // v11: third 8100 tag beyond MAX_VLAN=2 is reported as ethproto
    start_eth(16'h8100);
    put_n(64'h00018100, 4); put_n(64'h00028100, 4); put_n(64'h0003, 2); put_n(64'h45000000, 4);
    e = mk(11); e.vc = 2'd2; e.vid = 12'h001; e.eth = 16'h8100;
    send(e, 21, fb.size() - 1, 0, 1'b1);
    idle(2);

    // v12: IHL=3 -> trunc right after IP byte 0
    start_eth(16'h0800); put(8'h43); put_n(64'h0, 4);
    e = mk(12); e.trunc = 1'b1; e.eth = 16'h0800;
    send(e, 14, fb.size() - 1, 0, 1'b1);
    idle(2);

    // v13: EthII non-IP (IPv6 EtherType) -> ready one cycle after the type field
    start_eth(16'h86DD); put_n(64'h60000000, 4);
    e = mk(13); e.eth = 16'h86DD;
    send(e, 13, fb.size() - 1, 0, 1'b1);
    idle(2);

    for (int k = 0; k < 50 && sb.size() > 0; k++) @(posedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL v%0d missing_ready got=none want=pulse", e.id);
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
